alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes operand B from the ALU source mux output and operand A from the register-read path.
- Completes single-cycle ops with a registered result one cycle after accept.
- Completes unsigned MULTU/DIVU iteratively over 32 cycles, writing architectural HI/LO registers; MFHI/MFLO read them back.
- Uses a valid/ready handshake so the pipeline stalls while an iterative op is in flight.

---
 rtl/alu_exec_unit_if.sv | 28 ++
 rtl/alu_exec_unit.sv | 186 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Operation/result bundle between the execute-stage ALU and its pipeline neighbours.
// The master side issues operations; the slave side is the ALU.
interface alu_exec_unit_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             ovf;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output in_valid, alu_op, a, b, flush,
      input  in_ready, out_valid, result, zero, ovf, hi, lo
   );

   modport slave (
      input  in_valid, alu_op, a, b, flush,
      output in_ready, out_valid, result, zero, ovf, hi, lo
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle integer ops plus iterative unsigned MULTU/DIVU
// that write the architectural HI/LO pair over WIDTH cycles.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input logic            clk,
   input logic            rst_n,
   alu_exec_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLTU = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_LUI  = 4'd11;
   localparam logic [3:0] OP_MULT = 4'd12;
   localparam logic [3:0] OP_DIV  = 4'd13;
   localparam logic [3:0] OP_MFHI = 4'd14;
   localparam logic [3:0] OP_MFLO = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] work_hi_r, work_lo_r, opnd_r;
   logic             out_valid_r, zero_r, ovf_r;
   logic [WIDTH-1:0] result_r, hi_r, lo_r;

   logic [WIDTH-1:0] add_s, sub_s, alu_res_s;
   logic             alu_ovf_s;
   logic [WIDTH:0]   mul_sum_s, div_ext_s;
   logic [WIDTH-1:0] div_diff_s;
   logic             div_ge_s, last_s;
   logic [WIDTH-1:0] step_hi_s, step_lo_s;

   assign bus.in_ready  = (state_r == IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.zero      = zero_r;
   assign bus.ovf       = ovf_r;
   assign bus.hi        = hi_r;
   assign bus.lo        = lo_r;

   // Single-cycle result and signed overflow for the presented operation.
   always_comb begin
      add_s     = bus.a + bus.b;
      sub_s     = bus.a - bus.b;
      alu_res_s = {WIDTH{1'b0}};
      alu_ovf_s = 1'b0;
      case (bus.alu_op)
         OP_ADD: begin
            alu_res_s = add_s;
            alu_ovf_s = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_s[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res_s = sub_s;
            alu_ovf_s = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_s[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND:  alu_res_s = bus.a & bus.b;
         OP_OR:   alu_res_s = bus.a | bus.b;
         OP_XOR:  alu_res_s = bus.a ^ bus.b;
         OP_NOR:  alu_res_s = ~(bus.a | bus.b);
         OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         OP_SLL:  alu_res_s = bus.b << bus.a[4:0];
         OP_SRL:  alu_res_s = bus.b >> bus.a[4:0];
         OP_SRA:  alu_res_s = $signed(bus.b) >>> bus.a[4:0];
         OP_LUI:  alu_res_s = {bus.b[WIDTH-17:0], 16'h0000};
         OP_MFHI: alu_res_s = hi_r;
         OP_MFLO: alu_res_s = lo_r;
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // One iteration step: shift-add multiply or restoring divide on the shared work registers.
   always_comb begin
      mul_sum_s  = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      div_ext_s  = {work_hi_r, work_lo_r[WIDTH-1]};
      div_ge_s   = (div_ext_s >= {1'b0, opnd_r});
      // When the trial subtraction succeeds the true difference fits in WIDTH bits.
      div_diff_s = div_ext_s[WIDTH-1:0] - opnd_r;
      last_s     = (count_r == CW'(WIDTH - 1));
      if (state_r == MUL) begin
         step_hi_s = mul_sum_s[WIDTH:1];
         step_lo_s = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
      end else if (div_ge_s) begin
         step_hi_s = div_diff_s;
         step_lo_s = {work_lo_r[WIDTH-2:0], 1'b1};
      end else begin
         step_hi_s = div_ext_s[WIDTH-1:0];
         step_lo_s = {work_lo_r[WIDTH-2:0], 1'b0};
      end
   end

   // Next-state selection for the idle / multiply / divide sequencer.
   always_comb begin
      state_nxt_s = state_r;
      if (bus.flush) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid && bus.alu_op == OP_MULT) begin
                  state_nxt_s = MUL;
               end else if (bus.in_valid && bus.alu_op == OP_DIV) begin
                  state_nxt_s = DIV;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            MUL, DIV: begin
               if (last_s) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State register, iteration datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         count_r     <= {CW{1'b0}};
         work_hi_r   <= {WIDTH{1'b0}};
         work_lo_r   <= {WIDTH{1'b0}};
         opnd_r      <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         result_r    <= {WIDTH{1'b0}};
         zero_r      <= 1'b0;
         ovf_r       <= 1'b0;
         hi_r        <= {WIDTH{1'b0}};
         lo_r        <= {WIDTH{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         out_valid_r <= 1'b0;
         if (!bus.flush) begin
            case (state_r)
               IDLE: begin
                  if (bus.in_valid && (bus.alu_op == OP_MULT || bus.alu_op == OP_DIV)) begin
                     count_r   <= {CW{1'b0}};
                     work_hi_r <= {WIDTH{1'b0}};
                     // Multiply walks b's bits against a; divide shifts a in against divisor b.
                     work_lo_r <= (bus.alu_op == OP_MULT) ? bus.b : bus.a;
                     opnd_r    <= (bus.alu_op == OP_MULT) ? bus.a : bus.b;
                  end else if (bus.in_valid) begin
                     out_valid_r <= 1'b1;
                     result_r    <= alu_res_s;
                     zero_r      <= (alu_res_s == {WIDTH{1'b0}});
                     ovf_r       <= alu_ovf_s;
                  end
               end
               MUL, DIV: begin
                  work_hi_r <= step_hi_s;
                  work_lo_r <= step_lo_s;
                  count_r   <= count_r + {{(CW-1){1'b0}}, 1'b1};
                  if (last_s) begin
                     hi_r        <= step_hi_s;
                     lo_r        <= step_lo_s;
                     result_r    <= step_lo_s;
                     zero_r      <= (step_lo_s == {WIDTH{1'b0}});
                     ovf_r       <= 1'b0;
                     out_valid_r <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table for single-cycle ops, scoreboard
// on out_valid, and hand-written sequences for MULTU/DIVU, flush and reset.
module tb_alu_exec_unit;
   localparam int W = 32;
   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
      NOR_ = 4'd5, SLT = 4'd6, SLTU = 4'd7, SLL = 4'd8, SRL = 4'd9, SRA = 4'd10,
      LUI = 4'd11, MULTU = 4'd12, DIVU = 4'd13, MFHI = 4'd14, MFLO = 4'd15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_exec_unit_if #(.WIDTH(W)) bus ();
   alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
      logic         o;
   } exp_t;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         z;
      logic         o;
   } vec_t;

   localparam int NV = 15;
   vec_t         vecs[NV];
   exp_t         sb[$];
   int           tests = 0;
   int           fails = 0;
   logic [W-1:0] hi_exp = '0;
   logic [W-1:0] lo_exp = '0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge: presents an op, waits for the accept edge, queues its expectation.
   task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic z, input logic o, input bit push);
      exp_t e;
      bus.in_valid = 1'b1;
      bus.alu_op   = op;
      bus.a        = a;
      bus.b        = b;
      @(posedge clk);
      if (push) begin
         e.res = res;
         e.z   = z;
         e.o   = o;
         sb.push_back(e);
      end
   endtask

   // Called at a negedge: full MULTU/DIVU transaction with latency and HI/LO checks.
   task automatic run_iter(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
      int n = 0;
      int lows = 0;
      drive(op, a, b, el, (el == '0), 1'b0, 1'b1);
      do begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         n++;
         if (!bus.in_ready) lows++;
      end while (!bus.out_valid && n < 40);
      chk("iter_latency", n, 33);
      chk("iter_ready_low", lows, 32);
      chk("iter_hi", bus.hi, eh);
      chk("iter_lo", bus.lo, el);
      hi_exp = eh;
      lo_exp = el;
   endtask

   // Scoreboard: every out_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got result %h with nothing expected (t=%0t)", bus.result, $time);
         end else begin
            e = sb.pop_front();
            chk("sb_result", bus.result, e.res);
            chk("sb_zero", W'(bus.zero), W'(e.z));
            chk("sb_ovf", W'(bus.ovf), W'(e.o));
         end
      end
   end

   initial begin
      int ov;
      logic [W-1:0] ra, rb;
      logic [63:0]  p;
      bus.in_valid = 1'b0;
      bus.alu_op   = 4'd0;
      bus.a        = '0;
      bus.b        = '0;
      bus.flush    = 1'b0;

      vecs[0]  = '{ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
      vecs[1]  = '{SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
      vecs[2]  = '{SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
      vecs[3]  = '{SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
      vecs[4]  = '{SRA,  32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 1'b0};
      vecs[5]  = '{LUI,  32'h00000000, 32'h00001234, 32'h12340000, 1'b0, 1'b0};
      vecs[6]  = '{SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
      vecs[7]  = '{AND_, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
      vecs[8]  = '{OR_,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0, 1'b0};
      vecs[9]  = '{XOR_, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0};
      vecs[10] = '{NOR_, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[11] = '{SLL,  32'h0000001F, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
      vecs[12] = '{SRL,  32'h00000004, 32'h80000000, 32'h08000000, 1'b0, 1'b0};
      vecs[13] = '{ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
      vecs[14] = '{MFHI, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};

      repeat (2) @(negedge clk);
      chk("rst_out_valid", W'(bus.out_valid), '0);
      chk("rst_in_ready", W'(bus.in_ready), W'(1));
      chk("rst_result", bus.result, '0);
      chk("rst_hi", bus.hi, '0);
      chk("rst_lo", bus.lo, '0);
      rst_n = 1'b1;

      // Back-to-back single-cycle ops.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z, vecs[i].o, 1'b1);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);

      // MULTU, then MFLO accepted the cycle after completion, then MFHI.
      run_iter(MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
      drive(MFLO, '0, '0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      drive(MFHI, '0, '0, 32'h00000001, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);

      run_iter(DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      run_iter(DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);
      for (int k = 0; k < 3; k++) begin
         ra = $urandom;
         rb = $urandom;
         p  = 64'(ra) * 64'(rb);
         run_iter(MULTU, ra, rb, p[63:32], p[31:0]);
         rb = $urandom_range(1, 1000);
         run_iter(DIVU, ra, rb, ra % rb, ra / rb);
      end
      run_iter(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

      // Flush at cycle 10 of a MULTU: no result, HI/LO kept, ready next cycle.
      drive(MULTU, 32'd3, 32'd5, '0, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (c == 10) bus.flush = 1'b1;
      end
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_ready", W'(bus.in_ready), W'(1));
      ov = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid) ov++;
      end
      chk("flush_no_out", ov, 0);
      chk("flush_hi", bus.hi, hi_exp);
      chk("flush_lo", bus.lo, lo_exp);

      // Flush in the same cycle as an accept drops it.
      bus.flush = 1'b1;
      drive(ADD, 32'd1, 32'd1, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_drop", W'(bus.out_valid), '0);

      // Asynchronous reset in the middle of a DIVU.
      @(negedge clk);
      drive(DIVU, 32'd100, 32'd7, '0, 1'b0, 1'b0, 1'b0);
      repeat (10) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_result", bus.result, '0);
      chk("midrst_hi", bus.hi, '0);
      chk("midrst_lo", bus.lo, '0);
      chk("midrst_ready", W'(bus.in_ready), W'(1));
      chk("midrst_flags", {bus.out_valid, bus.zero, bus.ovf}, '0);
      hi_exp = '0;
      lo_exp = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive(ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_lo", bus.lo, lo_exp);

      chk("sb_drained", sb.size(), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
